// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: issues instruction-bus reads for the current PC and hands
// {inst, pc} to decode through an output register backed by a one-entry skid slot.
module if_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    output logic             pc_en_o,
    input  logic             flush_i,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    input  logic             stall_d_i,
    output logic             inst_valid_o,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] inst_pc_o,
    output logic [1:0]       dbg_state_o
);

    // Bus handshake: inst_req/inst_addr are held until inst_addr_ok (address accepted);
    // exactly one inst_data_ok follows per accepted address, never in the same cycle.
    // Decode handshake: an instruction moves when inst_valid_o && !stall_d_i.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] inst_addr_q, inst_addr_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             discard_q, discard_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_inst_q, out_inst_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;

    logic consume;
    logic keep_data;
    logic issue_ok;

    assign consume   = out_valid_q && !stall_d_i;
    assign keep_data = (state_q == ST_WAIT) && inst_data_ok && !discard_q && !flush_i;
    // A fresh issue needs a free skid slot and a PC that is not about to be redirected.
    assign issue_ok  = !flush_i && !skid_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inst_addr_q  <= RESET_PC;
            req_pc_q     <= RESET_PC;
            discard_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            inst_addr_q  <= inst_addr_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Delivery buffer: the output register is always the older entry.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    out_inst_d   = skid_inst_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            if (keep_data) begin
                if (!out_valid_d) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = inst_rdata;
                    out_pc_d    = req_pc_q;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_inst_d  = inst_rdata;
                    skid_pc_d    = req_pc_q;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        inst_addr_d = inst_addr_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_ok) begin
                    state_d     = ST_REQ;
                    inst_addr_d = pc_i;
                end
            end
            ST_REQ: begin
                if (inst_addr_ok) begin
                    state_d  = ST_WAIT;
                    req_pc_d = inst_addr_q;
                    if (flush_i) begin
                        discard_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    discard_d = 1'b0;
                    if (issue_ok) begin
                        state_d     = ST_REQ;
                        inst_addr_d = pc_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (flush_i) begin
                    // The response still owed for the old path must be swallowed.
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        inst_req    = (state_q == ST_REQ);
        pc_en_o     = (state_q == ST_REQ) && inst_addr_ok && !flush_i;
        dbg_state_o = state_q;
    end

    assign inst_addr    = inst_addr_q;
    assign inst_valid_o = out_valid_q;
    assign inst_o       = out_inst_q;
    assign inst_pc_o    = out_pc_q;

endmodule
